// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game round controller: phase encoding,
// FSM state type, BCD digit width and a binary-to-BCD helper used to
// build the round timer's load value from a binary seconds count.
package game_ctrl_pkg;

    localparam int BCD_W = 4;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_READY = 3'd1;
    localparam logic [2:0] PH_PLAY  = 3'd2;
    localparam logic [2:0] PH_PAUSE = 3'd3;
    localparam logic [2:0] PH_OVER  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = PH_IDLE,
        ST_READY = PH_READY,
        ST_PLAY  = PH_PLAY,
        ST_PAUSE = PH_PAUSE,
        ST_OVER  = PH_OVER
    } state_e;

    // Two-digit BCD image of a binary value in 0..99, tens in the high nibble.
    function automatic logic [2*BCD_W-1:0] bcd_of(input int unsigned val);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = BCD_W'((val / 10) % 10);
        ones = BCD_W'(val % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/game_phase_ctrl_bcd_down2.sv
// Two-digit BCD down counter used as the round timer. A load takes
// priority over a count; next_is_zero flags that one more decrement
// lands on 00, letting the controller leave PLAY on that same edge.
module bcd_down2
    import game_ctrl_pkg::*;
#(
    parameter logic [2*BCD_W-1:0] RESET_VAL = 8'h00
) (
    input  logic               clk_1H,
    input  logic               reset,
    input  logic               load,
    input  logic [2*BCD_W-1:0] load_val,
    input  logic               en,
    output logic [BCD_W-1:0]   tens,
    output logic [BCD_W-1:0]   ones,
    output logic               next_is_zero
);

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;

    // Next digit values: load, else BCD decrement with borrow from the tens digit.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (load) begin
            tens_d = load_val[2*BCD_W-1:BCD_W];
            ones_d = load_val[BCD_W-1:0];
        end else if (en) begin
            if (ones_q == '0) begin
                ones_d = BCD_W'(9);
                tens_d = tens_q - BCD_W'(1);
            end else begin
                ones_d = ones_q - BCD_W'(1);
            end
        end
    end

    // Digit registers; reset shows the configured round length at once.
    always_ff @(posedge clk_1H or posedge reset) begin
        if (reset) begin
            tens_q <= RESET_VAL[2*BCD_W-1:BCD_W];
            ones_q <= RESET_VAL[BCD_W-1:0];
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens         = tens_q;
    assign ones         = ones_q;
    assign next_is_zero = (tens_q == '0) && (ones_q == BCD_W'(1));

endmodule

// File: rtl/game_phase_ctrl.sv
// Game round sequencer: IDLE -> READY countdown -> PLAY/PAUSE -> OVER -> IDLE.
// Owns the lives, level and OVER-hold counters and drives the round timer.
// phase, endf and play_en decode straight from the state register.
module game_phase_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int GAME_SECS  = 60,
    parameter int READY_SECS = 3,
    parameter int LIVES      = 3,
    parameter int LEVEL_SECS = 10,
    parameter int MAX_LEVEL  = 8,
    parameter int OVER_SECS  = 5
) (
    input  logic             clk_1H,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             collision,
    output logic             endf,
    output logic             play_en,
    output logic [2:0]       phase,
    output logic [3:0]       ready_cnt,
    output logic [BCD_W-1:0] time_tens,
    output logic [BCD_W-1:0] time_ones,
    output logic [1:0]       lives,
    output logic [3:0]       level
);

    localparam logic [2*BCD_W-1:0] GAME_BCD = bcd_of(GAME_SECS);
    localparam int LSW = $clog2(LEVEL_SECS + 1);
    localparam int HW  = $clog2(OVER_SECS + 1);

    localparam logic [3:0]     READY_INIT = 4'(READY_SECS);
    localparam logic [1:0]     LIVES_INIT = 2'(LIVES);
    localparam logic [3:0]     LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [LSW-1:0] LSEC_LAST  = LSW'(LEVEL_SECS - 1);
    localparam logic [HW-1:0]  HOLD_LAST  = HW'(OVER_SECS - 1);

    state_e         state_q, state_d;
    logic [3:0]     ready_q, ready_d;
    logic [1:0]     lives_q, lives_d;
    logic [3:0]     level_q, level_d;
    logic [LSW-1:0] lsec_q,  lsec_d;
    logic [HW-1:0]  hold_q,  hold_d;

    logic tmr_load;
    logic tmr_en;
    logic tmr_next_zero;

    bcd_down2 #(
        .RESET_VAL (GAME_BCD)
    ) u_timer (
        .clk_1H       (clk_1H),
        .reset        (reset),
        .load         (tmr_load),
        .load_val     (GAME_BCD),
        .en           (tmr_en),
        .tens         (time_tens),
        .ones         (time_ones),
        .next_is_zero (tmr_next_zero)
    );

    // Next-state and counter updates for every phase.
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        lives_d  = lives_q;
        level_d  = level_q;
        lsec_d   = lsec_q;
        hold_d   = hold_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_READY;
                    ready_d  = READY_INIT;
                    lives_d  = LIVES_INIT;
                    level_d  = '0;
                    lsec_d   = '0;
                    tmr_load = 1'b1;
                end
            end

            ST_READY: begin
                ready_d = ready_q - 4'd1;
                if (ready_q == 4'd1) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                tmr_en = 1'b1;
                if (collision && (lives_q != '0)) begin
                    lives_d = lives_q - 2'd1;
                end
                if (lsec_q == LSEC_LAST) begin
                    lsec_d = '0;
                    if (level_q < LEVEL_MAX) begin
                        level_d = level_q + 4'd1;
                    end
                end else begin
                    lsec_d = lsec_q + LSW'(1);
                end
                if (tmr_next_zero || (lives_d == '0)) begin
                    state_d = ST_OVER;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (!pause) begin
                    state_d = ST_PLAY;
                end
            end

            ST_OVER: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with asynchronous reset to the idle defaults.
    always_ff @(posedge clk_1H or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready_q <= READY_INIT;
            lives_q <= LIVES_INIT;
            level_q <= '0;
            lsec_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            lives_q <= lives_d;
            level_q <= level_d;
            lsec_q  <= lsec_d;
            hold_q  <= hold_d;
        end
    end

    assign phase     = state_q;
    assign endf      = (state_q == ST_OVER);
    assign play_en   = (state_q == ST_PLAY);
    assign ready_cnt = ready_q;
    assign lives     = lives_q;
    assign level     = level_q;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Self-checking bench for game_phase_ctrl. An integer (non-BCD) reference
// model predicts each edge; predictions are queued when the stimulus is
// driven and compared after the edge. A second instance with a 99-second
// round checks level saturation.
module tb_game_phase_ctrl;

    logic       clk_1H;
    logic       reset;
    logic       start;
    logic       pause;
    logic       collision;
    logic       start99;

    logic       endf, play_en;
    logic [2:0] phase;
    logic [3:0] ready_cnt, time_tens, time_ones, level;
    logic [1:0] lives;

    logic       endf99, play_en99;
    logic [2:0] phase99;
    logic [3:0] ready_cnt99, time_tens99, time_ones99, level99;
    logic [1:0] lives99;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ph;
        int rdy;
        int tm;
        int lv;
        int lev;
    } exp_t;

    exp_t sb[$];

    int m_ph, m_rdy, m_tm, m_lv, m_lev, m_lsec, m_hold;

    game_phase_ctrl dut (
        .clk_1H    (clk_1H),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .collision (collision),
        .endf      (endf),
        .play_en   (play_en),
        .phase     (phase),
        .ready_cnt (ready_cnt),
        .time_tens (time_tens),
        .time_ones (time_ones),
        .lives     (lives),
        .level     (level)
    );

    game_phase_ctrl #(
        .GAME_SECS  (99),
        .LEVEL_SECS (10)
    ) dut99 (
        .clk_1H    (clk_1H),
        .reset     (reset),
        .start     (start99),
        .pause     (1'b0),
        .collision (1'b0),
        .endf      (endf99),
        .play_en   (play_en99),
        .phase     (phase99),
        .ready_cnt (ready_cnt99),
        .time_tens (time_tens99),
        .time_ones (time_ones99),
        .lives     (lives99),
        .level     (level99)
    );

    // 1 Hz tick scaled to a 10-unit period.
    initial clk_1H = 1'b0;
    always #5 clk_1H = ~clk_1H;

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_ph = 0; m_rdy = 3; m_tm = 60; m_lv = 3; m_lev = 0; m_lsec = 0; m_hold = 0;
    endtask

    task automatic modelStep(input logic s, input logic p, input logic c);
        case (m_ph)
            0: if (s) begin
                m_ph = 1; m_rdy = 3; m_tm = 60; m_lv = 3; m_lev = 0; m_lsec = 0;
            end
            1: begin
                if (m_rdy == 1) m_ph = 2;
                m_rdy = m_rdy - 1;
            end
            2: begin
                m_tm = m_tm - 1;
                if (c && m_lv > 0) m_lv = m_lv - 1;
                m_lsec = m_lsec + 1;
                if (m_lsec == 10) begin
                    m_lsec = 0;
                    if (m_lev < 8) m_lev = m_lev + 1;
                end
                if (m_tm == 0 || m_lv == 0) m_ph = 4;
                else if (p) m_ph = 3;
            end
            3: if (!p) m_ph = 2;
            4: begin
                m_hold = m_hold + 1;
                if (m_hold == 5) begin
                    m_hold = 0;
                    m_ph = 0;
                end
            end
            default: m_ph = 0;
        endcase
    endtask

    task automatic compareOne();
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            checkOutput("phase",     int'(phase),     e.ph);
            checkOutput("ready_cnt", int'(ready_cnt), e.rdy);
            checkOutput("time_tens", int'(time_tens), e.tm / 10);
            checkOutput("time_ones", int'(time_ones), e.tm % 10);
            checkOutput("lives",     int'(lives),     e.lv);
            checkOutput("level",     int'(level),     e.lev);
            checkOutput("endf",      int'(endf),      (e.ph == 4) ? 1 : 0);
            checkOutput("play_en",   int'(play_en),   (e.ph == 2) ? 1 : 0);
        end
    endtask

    // Drive one edge's inputs at the falling edge, predict, then compare after the rising edge.
    task automatic applyStimulus(input logic s, input logic p, input logic c);
        exp_t e;
        start = s; pause = p; collision = c;
        modelStep(s, p, c);
        e.ph = m_ph; e.rdy = m_rdy; e.tm = m_tm; e.lv = m_lv; e.lev = m_lev;
        sb.push_back(e);
        @(posedge clk_1H);
        #1;
        compareOne();
        @(negedge clk_1H);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_phase"}, int'(phase), 0);
        checkOutput({tag, "_endf"}, int'(endf), 0);
        checkOutput({tag, "_play_en"}, int'(play_en), 0);
        checkOutput({tag, "_ready"}, int'(ready_cnt), 3);
        checkOutput({tag, "_tens"}, int'(time_tens), 6);
        checkOutput({tag, "_ones"}, int'(time_ones), 0);
        checkOutput({tag, "_lives"}, int'(lives), 3);
        checkOutput({tag, "_level"}, int'(level), 0);
    endtask

    task automatic startRound();
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; collision = 1'b0; start99 = 1'b0;
        modelReset();
        @(negedge clk_1H);
        @(negedge clk_1H);
        checkResetState("rst");
        checkOutput("rst99_tens", int'(time_tens99), 9);
        checkOutput("rst99_ones", int'(time_ones99), 9);
        reset = 1'b0;

        $display("[TB] full round, no collisions");
        startRound();
        checkOutput("enter_play_phase", int'(phase), 2);
        checkOutput("enter_play_time", int'(time_tens) * 10 + int'(time_ones), 60);
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("round_end_endf", int'(endf), 1);
        checkOutput("round_end_level", int'(level), 6);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("over_exit_phase", int'(phase), 0);
        checkOutput("over_exit_time", int'(time_tens) * 10 + int'(time_ones), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] lives run out");
        startRound();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lives_out_phase", int'(phase), 4);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("over_frozen_time", int'(time_tens) * 10 + int'(time_ones), 55);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] pause and resume");
        startRound();
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pause_phase", int'(phase), 3);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("pause_hold_time", int'(time_tens) * 10 + int'(time_ones), 44);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("resume_time", int'(time_tens) * 10 + int'(time_ones), 44);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("resume_next_time", int'(time_tens) * 10 + int'(time_ones), 43);

        $display("[TB] asynchronous reset mid-round");
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_time", int'(time_tens) * 10 + int'(time_ones), 37);
        checkOutput("pre_reset_lives", int'(lives), 2);
        #2;
        reset = 1'b1;
        #1;
        checkResetState("async");
        modelReset();
        reset = 1'b0;
        @(negedge clk_1H);
        checkOutput("sb_drained", sb.size(), 0);

        $display("[TB] 99 second round level saturation");
        start99 = 1'b1;
        @(posedge clk_1H); #1; @(negedge clk_1H);
        start99 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_1H); #1; @(negedge clk_1H);
        end
        checkOutput("r99_play", int'(phase99), 2);
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk_1H);
            #1;
            if (k == 79) checkOutput("r99_level79", int'(level99), 7);
            if (k == 80) checkOutput("r99_level80", int'(level99), 8);
            if (k == 90) begin
                checkOutput("r99_level90", int'(level99), 8);
                checkOutput("r99_time90", int'(time_tens99) * 10 + int'(time_ones99), 9);
                checkOutput("r99_phase90", int'(phase99), 2);
            end
            @(negedge clk_1H);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_phase_ctrl.md
Name: game_phase_ctrl

Overview:
- Sequences one game round: IDLE -> READY countdown -> PLAY (with PAUSE) -> OVER -> IDLE.
- Owns the 2-digit BCD round timer, the lives counter and the level counter.
- Drives the game-end flag (endf) and a play enable for the sprite/motion logic.
- Its digit outputs feed the 7-segment/VGA score display. Everything ticks at 1 Hz.

Parameters:
- GAME_SECS, 60, round length in seconds; binary value, 1..99, loaded as BCD.
- READY_SECS, 3, countdown length in cycles; 1..9.
- LIVES, 3, starting lives; 1..3.
- LEVEL_SECS, 10, PLAY cycles per level increment; >=1.
- MAX_LEVEL, 8, level saturation value; <=15.
- OVER_SECS, 5, cycles spent in OVER before returning to IDLE; >=1.

Ports:
- clk_1H  in  1  1 Hz game tick.
- reset  in  1  asynchronous, active-high.
- start  in  1  level-sampled; begins a round from IDLE.
- pause  in  1  level; requests PAUSE while high.
- collision  in  1  level-sampled; one life lost per PLAY edge where it is high.
- endf  out  1  high exactly while phase==OVER.
- play_en  out  1  high exactly while phase==PLAY.
- phase  out  3  encoding: 0 IDLE, 1 READY, 2 PLAY, 3 PAUSE, 4 OVER.
- ready_cnt  out  4  remaining countdown, binary.
- time_tens  out  4  BCD tens of remaining time.
- time_ones  out  4  BCD ones of remaining time.
- lives  out  2  remaining lives.
- level  out  4  current level, 0..MAX_LEVEL.

Behaviour:
- Decided interface: reset reset, asynchronous, active-high; clock clk_1H.
- All outputs are registered. endf, play_en and phase decode directly from the state register.
- Reset (asserted at any time, including mid-round) forces, immediately:
  - phase=IDLE, endf=0, play_en=0;
  - ready_cnt=READY_SECS, time=BCD(GAME_SECS), lives=LIVES, level=0;
  - internal level-second and over-hold counters to 0.
- IDLE:
  - start=1 at an edge -> READY.
  - The same edge reloads ready_cnt=READY_SECS, time=GAME_SECS, lives=LIVES, level=0 and the level-second counter to 0.
  - Otherwise all values hold; the previous round's results stay displayed.
- READY:
  - Each edge decrements ready_cnt.
  - The edge where ready_cnt==1 goes to PLAY with ready_cnt=0, so READY lasts exactly READY_SECS cycles.
  - pause, collision and start are ignored.
- PLAY: every edge is one play second. All of the following happen on the same edge.
  - Time: decrements in BCD. ones==0 borrows, giving ones=9 and tens-1.
  - Lives: if collision=1, lives decrements; no underflow.
  - Level: level-second counter increments; on reaching LEVEL_SECS it clears and level+1, saturating at MAX_LEVEL.
  - Next state, in priority order:
    - OVER if the new time==00 or the new lives==0 (both may coincide);
    - else PAUSE if pause=1;
    - else PLAY.
- PAUSE:
  - Time, lives, level and the level-second counter all freeze. collision and start are ignored.
  - pause=0 at an edge -> PLAY. That transition edge does not count as a play second.
- OVER:
  - endf=1; time, lives and level are frozen.
  - The hold counter counts OVER_SECS edges, then -> IDLE with endf=0 and the hold counter cleared.
  - start is ignored in OVER.
- Width rules:
  - time is always valid BCD: tens 0..9, ones 0..9.
  - Decrement is never applied at 00, because PLAY has already left for OVER.
  - level never exceeds MAX_LEVEL.

Decomposition:
- Package game_ctrl_pkg holds:
  - phase encoding localparams (PH_IDLE=0 .. PH_OVER=4);
  - BCD digit width 4 and a BCD-of-binary constant function used for the GAME_SECS load.
- Sub-module bcd_down2: two-digit BCD down counter.
  - Inputs: load, load value, en.
  - Outputs: tens, ones, and a next_is_zero flag.
  - Instantiated once for the round timer.
- The FSM, lives, level and hold counters stay in game_phase_ctrl.

Test Plan:
- Reset, then start=1 for one edge:
  - phase=1 with ready_cnt 3,2,1 over three edges;
  - 4th edge: phase=2, play_en=1, time=60, lives=3, level=0.
- 60 PLAY edges, no collision or pause:
  - time runs 59..00, with 10 -> 09 borrow checked;
  - level=6 at the end;
  - the 60th edge gives phase=4, endf=1;
  - 5 edges later phase=0, endf=0, and time stays 00.
- collision=1 on three separate PLAY edges: lives 2,1,0; phase=4 on the third edge with time frozen.
- At time=45, pause=1 before the edge:
  - that edge gives time=44, phase=3;
  - hold 4 edges: time stays 44;
  - pause=0: next edge gives phase=2, time=44; the following edge gives 43.
- GAME_SECS=99, LEVEL_SECS=10 override: level reaches 8 at the 80th edge and stays 8 through the 90th.
- Async reset mid-PLAY at time=37, lives=2: outputs return at once to phase=0, time=60, lives=3, level=0, endf=0, with no clock edge needed.
